serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Control and handshake stage that sits upstream of the team's bit-serial adder datapath and collects its result.
- Accepts an operand pair plus carry-in on a valid/ready interface.
- Drives the datapath through load and shift phases, then captures the parallel sum and carry-out.
- Presents the result on a valid/ready output with a one-entry result buffer, so the next operation can start while the previous result waits to be consumed.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), shift-counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- dp_load  output  1  datapath load strobe (one cycle).
- dp_shift  output  1  datapath shift enable; one bit processed per cycle while high.
- dp_a  output  WIDTH  operand A to datapath (held from accept until next accept).
- dp_b  output  WIDTH  operand B to datapath (held from accept until next accept).
- dp_cin  output  1  carry-in to datapath (held from accept until next accept).
- dp_sum  input  WIDTH  parallel sum from datapath; valid in CAPT state.
- dp_cout  input  1  final carry from datapath; valid in CAPT state.
- res_valid  output  1  result buffer holds a result.
- res_ready  input  1  consumer accepts result.
- res_sum  output  WIDTH  result sum.
- res_cout  output  1  result carry-out.
- res_ovf  output  1  signed overflow flag (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-high, named reset.
- Reset values:
  - State is IDLE and the counter is 0.
  - in_ready=1 and busy=0.
  - dp_load=0, dp_shift=0, dp_a=0, dp_b=0, dp_cin=0.
  - res_valid=0, res_sum=0, res_cout=0, res_ovf=0.
- Datapath contract:
  - On the edge ending a cycle with dp_load=1, the datapath loads dp_a, dp_b and dp_cin and clears its sum register.
  - Each edge with dp_shift=1 processes one bit, LSB first.
  - After exactly WIDTH shift edges, dp_sum and dp_cout are final.
- All outputs are registered except in_ready and busy, which are decoded from state.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_a, in_b and in_cin into dp_a, dp_b and dp_cin, then go to LOAD.
  - LOAD: dp_load=1 for exactly one cycle; counter cleared; then go to SHIFT.
  - SHIFT: dp_shift=1; counter increments each edge. When counter==WIDTH-1, go to CAPT. Exactly WIDTH cycles with dp_shift=1.
  - CAPT: dp_shift=0.
    - If res_valid==0 or res_ready==1: load res_sum=dp_sum and res_cout=dp_cout, set res_valid=1, go to IDLE.
    - Otherwise stay in CAPT and do not capture.
- Result buffer:
  - res_valid clears on res_valid&res_ready unless a capture occurs on the same edge; capture wins and res_valid stays 1 with the new data.
  - res_sum, res_cout and res_ovf are stable while res_valid=1 and res_ready=0.
- Latency:
  - With the accept on edge E0, res_valid rises after edge E(WIDTH+2), assuming no backpressure.
  - in_ready returns in the following cycle.
  - Peak throughput is one operation per WIDTH+3 cycles.
- Overlap: a new operation may be accepted and run while an older result is pending in the buffer; only CAPT stalls.
- Arithmetic: unsigned sum modulo 2^WIDTH. res_cout is the carry out of the MSB, so {res_cout,res_sum} = in_a + in_b + in_cin.
- in_valid while busy: ignored. Upstream must hold in_valid and its data until in_ready.
- Reset mid-operation: asynchronous return to IDLE with all reset values. Any pending result is discarded, and no dp_load or dp_shift pulse is emitted after reset asserts.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- When defined:
  - res_ovf = (dp_a[WIDTH-1]==dp_b[WIDTH-1]) && (dp_sum[WIDTH-1]!=dp_a[WIDTH-1]).
  - It is captured in CAPT alongside res_sum and follows the same hold rules.
- When undefined: res_ovf is tied to 0 and no overflow logic is synthesised.

Test Plan:
- Basic add, using the team's serial adder or a behavioural datapath model; WIDTH=8.
  - Stimulus: in_a=0x35, in_b=0x4A, in_cin=0, res_ready=1.
  - Response: res_sum=0x7F, res_cout=0 at edge E10; exactly 8 dp_shift cycles and 1 dp_load cycle.
- Carry chain.
  - Stimulus: in_a=0xFF, in_b=0x01, in_cin=1.
  - Response: res_sum=0x01, res_cout=1; in_ready low throughout LOAD, SHIFT and CAPT.
- Backpressure.
  - Stimulus: two ops, 0x10+0x20 then 0x0F+0x0F, with res_ready=0 for 30 cycles.
  - Response: first result 0x30 held stable; FSM parks in CAPT; after res_ready=1, 0x30 is consumed and then 0x1E appears on the next edge.
- Simultaneous capture and drain.
  - Stimulus: res_ready=1 on the same edge that CAPT completes.
  - Response: res_valid stays 1 and the data switches to the new result with no bubble.
- Reset mid-SHIFT.
  - Stimulus: assert reset in the 4th shift cycle of 0xAA+0x55.
  - Response: all outputs go to reset values immediately and in_ready=1. A subsequent 0x01+0x02 gives res_sum=0x03.
- Overflow with SERIAL_ADD_OVF_EN.
  - Stimulus: 0x7F+0x01.
  - Response: res_ovf=1 with the macro defined, 0 without; 0x80+0x80 gives res_ovf=1 and res_cout=1 with the macro defined.

Source files
------------

// File: rtl/serial_add_seq_if.sv
// Handshake and datapath bus for serial_add_seq: operand input, result output,
// and the load/shift strobes to the bit-serial adder.
interface serial_add_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             dp_load;
  logic             dp_shift;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_cin;
  logic [WIDTH-1:0] dp_sum;
  logic             dp_cout;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;
  logic             busy;

  // master: the sequencer; slave: upstream, datapath and result consumer
  modport master (
    input  in_valid, in_a, in_b, in_cin, dp_sum, dp_cout, res_ready,
    output in_ready, dp_load, dp_shift, dp_a, dp_b, dp_cin,
           res_valid, res_sum, res_cout, res_ovf, busy
  );
  modport slave (
    output in_valid, in_a, in_b, in_cin, dp_sum, dp_cout, res_ready,
    input  in_ready, dp_load, dp_shift, dp_a, dp_b, dp_cin,
           res_valid, res_sum, res_cout, res_ovf, busy
  );
endinterface

// File: rtl/serial_add_seq.sv
// Load/shift/capture sequencer for a bit-serial adder with a one-entry result buffer.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_add_seq_if.master  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dp_load_q, dp_shift_q, dp_cin_q;
  logic [WIDTH-1:0] dp_a_q, dp_b_q, res_sum_q;
  logic             res_valid_q, res_cout_q;
  logic             capt_go;

  // Capture is allowed when the buffer is empty or draining on this edge.
  assign capt_go = (state == CAPT) && (!res_valid_q || bus.res_ready);

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.dp_load   = dp_load_q;
  assign bus.dp_shift  = dp_shift_q;
  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.dp_cin    = dp_cin_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dp_load_q   <= 1'b0;
      dp_shift_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_cin_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      dp_load_q <= 1'b0;
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          dp_a_q    <= bus.in_a;
          dp_b_q    <= bus.in_b;
          dp_cin_q  <= bus.in_cin;
          dp_load_q <= 1'b1;
          state     <= LOAD;
        end
        LOAD: begin
          cnt        <= '0;
          dp_shift_q <= 1'b1;
          state      <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            dp_shift_q <= 1'b0;
            state      <= CAPT;
          end
        end
        CAPT: if (capt_go) begin
          res_sum_q   <= bus.dp_sum;
          res_cout_q  <= bus.dp_cout;
          res_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic res_ovf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        res_ovf_q <= 1'b0;
    else if (capt_go) res_ovf_q <= (dp_a_q[WIDTH-1] == dp_b_q[WIDTH-1]) &&
                                   (bus.dp_sum[WIDTH-1] != dp_a_q[WIDTH-1]);
  end
  assign bus.res_ovf = res_ovf_q;
`else
  assign bus.res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a behavioural bit-serial adder model.
module tb_serial_add_seq;
  localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_ld = 0, n_sh = 0;

  serial_add_seq_if #(.WIDTH(W)) bus ();
  serial_add_seq #(.WIDTH(W)) dut (.clk(clk), .reset(rst), .bus(bus.master));

  always #5 clk = ~clk;

  // behavioural LSB-first serial adder
  logic [W-1:0] ma, mb, ms;
  logic         mc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0; mb <= '0; ms <= '0; mc <= 1'b0;
    end else if (bus.dp_load) begin
      ma <= bus.dp_a; mb <= bus.dp_b; mc <= bus.dp_cin; ms <= '0;
    end else if (bus.dp_shift) begin
      ms <= {ma[0] ^ mb[0] ^ mc, ms[W-1:1]};
      mc <= (ma[0] & mb[0]) | (mc & (ma[0] ^ mb[0]));
      ma <= ma >> 1;
      mb <= mb >> 1;
    end
  end
  assign bus.dp_sum  = ms;
  assign bus.dp_cout = mc;

  always @(posedge clk) begin
    if (bus.dp_load)  n_ld++;
    if (bus.dp_shift) n_sh++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = c;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy_busy"}, {bus.in_ready, bus.busy}, 2'b10);
    chk({tag, "_dp"}, {bus.dp_load, bus.dp_shift, bus.dp_a, bus.dp_b, bus.dp_cin}, '0);
    chk({tag, "_res"}, {bus.res_valid, bus.res_sum, bus.res_cout, bus.res_ovf}, '0);
  endtask

  int l0, s0, bad;

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.res_ready = 1'b1;
    step(); step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // basic add: result visible after E10, one load and eight shifts
    l0 = n_ld; s0 = n_sh;
    accept(8'h35, 8'h4A, 1'b0);
    chk("basic_load", {bus.dp_load, bus.busy, bus.in_ready}, 3'b110);
    chk("basic_dpa", bus.dp_a, 8'h35);
    repeat (9) step();
    chk("basic_e9_novalid", bus.res_valid, 1'b0);
    step();
    chk("basic_e10_valid", bus.res_valid, 1'b1);
    chk("basic_sum", {bus.res_cout, bus.res_sum}, 9'h07F);
    chk("basic_rdy_back", bus.in_ready, 1'b1);
    chk("basic_nld", n_ld - l0, 1);
    chk("basic_nsh", n_sh - s0, 8);
    step();
    chk("basic_drained", bus.res_valid, 1'b0);

    // carry chain; in_valid held with other data while busy must be ignored
    bad = 0;
    accept(8'hFF, 8'h01, 1'b1);
    bus.in_valid = 1'b1; bus.in_a = 8'h5A; bus.in_b = 8'hA5;
    if (bus.in_ready !== 1'b0) bad++;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.in_ready !== 1'b0) bad++;
    end
    chk("carry_rdy_low", bad, 0);
    chk("carry_ignore_busy", bus.dp_a, 8'hFF);
    bus.in_valid = 1'b0;
    step();
    chk("carry_sum", {bus.res_valid, bus.res_cout, bus.res_sum}, 10'h301);
    step();

    // backpressure: second op parks in CAPT while 0x30 is held
    bus.res_ready = 1'b0;
    accept(8'h10, 8'h20, 1'b0);
    repeat (10) step();
    chk("bp_first", {bus.res_valid, bus.res_sum}, 9'h130);
    accept(8'h0F, 8'h0F, 1'b0);
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if ({bus.res_valid, bus.res_sum, bus.res_cout} !== 10'h260) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    chk("bp_parked", {bus.busy, bus.in_ready, bus.dp_shift}, 3'b100);
    bus.res_ready = 1'b1;
    step();
    chk("bp_second", {bus.res_valid, bus.res_sum}, 9'h11E);
    chk("bp_idle", bus.in_ready, 1'b1);
    step();
    chk("bp_drained", bus.res_valid, 1'b0);

    // capture and drain on the same edge: no bubble
    bus.res_ready = 1'b0;
    accept(8'h11, 8'h22, 1'b0);
    repeat (10) step();
    accept(8'h05, 8'h06, 1'b0);
    repeat (9) step();
    chk("sim_old_held", {bus.res_valid, bus.res_sum}, 9'h133);
    bus.res_ready = 1'b1;
    step();
    chk("sim_new", {bus.res_valid, bus.res_sum, bus.res_cout}, 10'h216);
    step();
    chk("sim_drained", bus.res_valid, 1'b0);

    // reset in the 4th shift cycle, with a result pending
    bus.res_ready = 1'b0;
    accept(8'h01, 8'h01, 1'b0);
    repeat (10) step();
    accept(8'hAA, 8'h55, 1'b0);
    repeat (4) step();
    chk("rst_in_shift", bus.dp_shift, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    l0 = n_ld; s0 = n_sh;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("rst_no_pulses", (n_ld - l0) + (n_sh - s0), 0);
    bus.res_ready = 1'b1;
    accept(8'h01, 8'h02, 1'b0);
    repeat (10) step();
    chk("rst_after_op", {bus.res_valid, bus.res_cout, bus.res_sum}, 10'h203);
    step();

    // signed overflow
    accept(8'h7F, 8'h01, 1'b0);
    repeat (10) step();
    chk("ovf_7f01", {bus.res_ovf, bus.res_cout, bus.res_sum}, {OVF, 9'h080});
    step();
    accept(8'h80, 8'h80, 1'b0);
    repeat (10) step();
    chk("ovf_8080", {bus.res_ovf, bus.res_cout, bus.res_sum}, {OVF, 9'h100});
    step();
    accept(8'h12, 8'h34, 1'b0);
    repeat (10) step();
    chk("ovf_none", {bus.res_ovf, bus.res_cout, bus.res_sum}, 10'h046);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
